// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator with pixel counters, syncs and frame pulse.
// Ports: clk, reset (sync, active high) in; pixel_tick, x[9:0], y[9:0], isdisplayed,
//        hsync/vsync (active low), frame_start out.
// Define VGA_CLKDIV_EN to advance one pixel every 2 clk; otherwise clk is the pixel clock.
module vga_timing_gen #(
  parameter logic [9:0] HACTIVE = 10'd640,
  parameter logic [9:0] HFP     = 10'd16,
  parameter logic [9:0] HSYNC   = 10'd96,
  parameter logic [9:0] HBP     = 10'd48,
  parameter logic [9:0] VACTIVE = 10'd480,
  parameter logic [9:0] VFP     = 10'd10,
  parameter logic [9:0] VSYNC   = 10'd2,
  parameter logic [9:0] VBP     = 10'd33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pixel_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       isdisplayed,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);
  localparam logic [9:0] HTOTAL   = HACTIVE + HFP + HSYNC + HBP;
  localparam logic [9:0] VTOTAL   = VACTIVE + VFP + VSYNC + VBP;
  localparam logic [9:0] HS_START = HACTIVE + HFP;
  localparam logic [9:0] HS_END   = HACTIVE + HFP + HSYNC;
  localparam logic [9:0] VS_START = VACTIVE + VFP;
  localparam logic [9:0] VS_END   = VACTIVE + VFP + VSYNC;
  logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic       h_end, v_end;
`ifdef VGA_CLKDIV_EN
  logic phase_q, phase_d;
  always_comb phase_d = ~phase_q;
  always_ff @(posedge clk) phase_q <= reset ? 1'b0 : phase_d;
  assign pixel_tick = phase_q;
`else
  assign pixel_tick = 1'b1;
`endif
  always_comb begin
    h_end  = hcnt_q == HTOTAL - 10'd1;
    v_end  = vcnt_q == VTOTAL - 10'd1;
    hcnt_d = !pixel_tick ? hcnt_q : h_end ? 10'd0 : hcnt_q + 10'd1;
    vcnt_d = !(pixel_tick && h_end) ? vcnt_q : v_end ? 10'd0 : vcnt_q + 10'd1;
  end
  always_ff @(posedge clk) begin
    hcnt_q <= reset ? 10'd0 : hcnt_d;
    vcnt_q <= reset ? 10'd0 : vcnt_d;
  end
  // All decodes come straight off the counter registers so they align with x/y.
  assign x           = hcnt_q;
  assign y           = vcnt_q;
  assign isdisplayed = hcnt_q < HACTIVE && vcnt_q < VACTIVE;
  assign hsync       = !(hcnt_q >= HS_START && hcnt_q < HS_END);
  assign vsync       = !(vcnt_q >= VS_START && vcnt_q < VS_END);
  assign frame_start = hcnt_q == 10'd0 && vcnt_q == 10'd0 && pixel_tick;
endmodule
